de_agex_latch: RTL and testbench

- Decode-stage logic plus the DE→AGEX pipeline register for the pipelined LC-3b.
- Forms the control-store address from the DE instruction and consumes the 23 control bits.
- Reads the register file, detects data/CC dependencies against the AGEX, MEM and SR stages, and raises the branch stall.
- Latches the AGEX-stage fields under the downstream load enable.

---
 rtl/lc3b_pkg.sv | 45 ++++
 rtl/de_dep_check.sv | 33 +++
 rtl/de_agex_latch.sv | 96 +++++++++
 tb/tb_de_agex_latch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b pipeline: datapath widths, control-store
// bit positions and the IDs that index the later pipeline stages.
package lc3b_pkg;

    localparam int CS_WIDTH      = 23;
    localparam int AGEX_CS_WIDTH = 20;
    localparam int WORD          = 16;

    localparam int SR1_NEEDED    = 0;
    localparam int SR2_NEEDED    = 1;
    localparam int DRMUX         = 2;
    localparam int ADDR1MUX      = 3;
    localparam int ADDR2MUX0     = 4;
    localparam int ADDR2MUX1     = 5;
    localparam int LSHF1         = 6;
    localparam int ADDRESSMUX    = 7;
    localparam int SR2MUX        = 8;
    localparam int ALUK0         = 9;
    localparam int ALUK1         = 10;
    localparam int ALU_RESULTMUX = 11;
    localparam int BR_OP         = 12;
    localparam int UNCOND_OP     = 13;
    localparam int TRAP_OP       = 14;
    localparam int BR_STALL      = 15;
    localparam int DCACHE_EN     = 16;
    localparam int DCACHE_RW     = 17;
    localparam int DATA_SIZE     = 18;
    localparam int DR_VALUEMUX0  = 19;
    localparam int DR_VALUEMUX1  = 20;
    localparam int LD_REG        = 21;
    localparam int LD_CC         = 22;

    localparam int NUM_STAGES = 3;

    typedef enum logic [1:0] {
        STAGE_AGEX = 2'd0,
        STAGE_MEM  = 2'd1,
        STAGE_SR   = 2'd2
    } stage_id_e;

    function automatic logic [5:0] cs_address(input logic [WORD-1:0] ir);
        return {ir[15:11], ir[5]};
    endfunction

endpackage

// File: rtl/de_dep_check.sv
// Purely combinational dependency detector: compares the DE source registers
// and the branch's CC use against writes pending in AGEX, MEM and SR.
module de_dep_check
    import lc3b_pkg::*;
(
    input  logic                       de_valid,
    input  logic                       sr1_needed,
    input  logic                       sr2_needed,
    input  logic                       br_op,
    input  logic [2:0]                 sr1_addr,
    input  logic [2:0]                 sr2_addr,
    input  logic [NUM_STAGES-1:0][2:0] drid,
    input  logic [NUM_STAGES-1:0]      v_ld_reg,
    input  logic [NUM_STAGES-1:0]      v_ld_cc,
    output logic                       dep_stall
);

    logic [NUM_STAGES-1:0] hit_sr1;
    logic [NUM_STAGES-1:0] hit_sr2;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign hit_sr1[gi] = v_ld_reg[gi] & (drid[gi] == sr1_addr);
            assign hit_sr2[gi] = v_ld_reg[gi] & (drid[gi] == sr2_addr);
        end
    endgenerate

    // SR is always checked: the register file gives no same-cycle write-through.
    assign dep_stall = de_valid & ((sr1_needed & (|hit_sr1)) |
                                   (sr2_needed & (|hit_sr2)) |
                                   (br_op & (|v_ld_cc)));

endmodule

// File: rtl/de_agex_latch.sv
// Decode stage of the pipelined LC-3b and the DE->AGEX pipeline register.
// The valid bit alone is gated by the dependency stall; data always loads.
module de_agex_latch
    import lc3b_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     de_valid,
    input  logic [WORD-1:0]          de_ir,
    input  logic [WORD-1:0]          de_npc,
    output logic [5:0]               cs_addr,
    input  logic [CS_WIDTH-1:0]      cs_bits,
    output logic [2:0]               rf_sr1_addr,
    output logic [2:0]               rf_sr2_addr,
    input  logic [WORD-1:0]          rf_sr1_data,
    input  logic [WORD-1:0]          rf_sr2_data,
    input  logic [2:0]               agex_drid_in,
    input  logic [2:0]               mem_drid_in,
    input  logic [2:0]               sr_drid_in,
    input  logic                     agex_v_ld_reg,
    input  logic                     mem_v_ld_reg,
    input  logic                     sr_v_ld_reg,
    input  logic                     agex_v_ld_cc,
    input  logic                     mem_v_ld_cc,
    input  logic                     sr_v_ld_cc,
    input  logic                     ld_agex,
    output logic                     dep_stall,
    output logic                     v_de_br_stall,
    output logic                     ld_de,
    output logic                     agex_valid,
    output logic [WORD-1:0]          agex_npc,
    output logic [WORD-1:0]          agex_ir,
    output logic [WORD-1:0]          agex_sr1,
    output logic [WORD-1:0]          agex_sr2,
    output logic [AGEX_CS_WIDTH-1:0] agex_cs,
    output logic [2:0]               agex_drid
);

    logic [NUM_STAGES-1:0][2:0] stage_drid;
    logic [NUM_STAGES-1:0]      stage_v_ld_reg;
    logic [NUM_STAGES-1:0]      stage_v_ld_cc;
    logic [2:0]                 drid;

    assign cs_addr     = cs_address(de_ir);
    assign rf_sr1_addr = de_ir[8:6];
    // Stores read the source data register from [11:9].
    assign rf_sr2_addr = de_ir[13] ? de_ir[11:9] : de_ir[2:0];
    assign drid        = cs_bits[DRMUX] ? 3'b111 : de_ir[11:9];

    assign stage_drid[STAGE_AGEX]     = agex_drid_in;
    assign stage_drid[STAGE_MEM]      = mem_drid_in;
    assign stage_drid[STAGE_SR]       = sr_drid_in;
    assign stage_v_ld_reg[STAGE_AGEX] = agex_v_ld_reg;
    assign stage_v_ld_reg[STAGE_MEM]  = mem_v_ld_reg;
    assign stage_v_ld_reg[STAGE_SR]   = sr_v_ld_reg;
    assign stage_v_ld_cc[STAGE_AGEX]  = agex_v_ld_cc;
    assign stage_v_ld_cc[STAGE_MEM]   = mem_v_ld_cc;
    assign stage_v_ld_cc[STAGE_SR]    = sr_v_ld_cc;

    de_dep_check u_dep_check (
        .de_valid   (de_valid),
        .sr1_needed (cs_bits[SR1_NEEDED]),
        .sr2_needed (cs_bits[SR2_NEEDED]),
        .br_op      (cs_bits[BR_OP]),
        .sr1_addr   (rf_sr1_addr),
        .sr2_addr   (rf_sr2_addr),
        .drid       (stage_drid),
        .v_ld_reg   (stage_v_ld_reg),
        .v_ld_cc    (stage_v_ld_cc),
        .dep_stall  (dep_stall)
    );

    assign v_de_br_stall = de_valid & cs_bits[BR_STALL];
    assign ld_de         = ld_agex & ~dep_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            agex_valid <= 1'b0;
            agex_npc   <= '0;
            agex_ir    <= '0;
            agex_sr1   <= '0;
            agex_sr2   <= '0;
            agex_cs    <= '0;
            agex_drid  <= '0;
        end else if (ld_agex) begin
            agex_valid <= de_valid & ~dep_stall;
            agex_npc   <= de_npc;
            agex_ir    <= de_ir;
            agex_sr1   <= rf_sr1_data;
            agex_sr2   <= rf_sr2_data;
            agex_cs    <= cs_bits[CS_WIDTH-1:3];
            agex_drid  <= drid;
        end
    end

endmodule

// File: tb/tb_de_agex_latch.sv
// Directed-vector bench for de_agex_latch with a tiny control-store and
// register-file model; expected values are hand-derived from the instruction encodings.
module tb_de_agex_latch;
    import lc3b_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     de_valid;
    logic [WORD-1:0]          de_ir;
    logic [WORD-1:0]          de_npc;
    logic [5:0]               cs_addr;
    logic [CS_WIDTH-1:0]      cs_bits;
    logic [2:0]               rf_sr1_addr, rf_sr2_addr;
    logic [WORD-1:0]          rf_sr1_data, rf_sr2_data;
    logic [2:0]               agex_drid_in, mem_drid_in, sr_drid_in;
    logic                     agex_v_ld_reg, mem_v_ld_reg, sr_v_ld_reg;
    logic                     agex_v_ld_cc, mem_v_ld_cc, sr_v_ld_cc;
    logic                     ld_agex;
    logic                     dep_stall, v_de_br_stall, ld_de;
    logic                     agex_valid;
    logic [WORD-1:0]          agex_npc, agex_ir, agex_sr1, agex_sr2;
    logic [AGEX_CS_WIDTH-1:0] agex_cs;
    logic [2:0]               agex_drid;

    int n_checks = 0;
    int n_pass   = 0;

    // Control words (bit positions from the package)
    localparam logic [22:0] CS_ADD  = 23'h600003; // SR1/SR2 needed, LD_REG, LD_CC
    localparam logic [22:0] CS_BR   = 23'h009000; // BR_OP, BR_STALL
    localparam logic [22:0] CS_STW  = 23'h070003; // SR1/SR2 needed, DCACHE_EN/RW, DATA_SIZE
    localparam logic [22:0] CS_TRAP = 23'h20C004; // DRMUX, TRAP_OP, BR_STALL, LD_REG

    localparam logic [15:0] IR_ADD  = 16'h1283;   // ADD R1,R2,R3
    localparam logic [15:0] IR_BRZ  = 16'h0402;
    localparam logic [15:0] IR_STW  = 16'h7940;   // STW R4,R5,#0
    localparam logic [15:0] IR_TRAP = 16'hF025;

    function automatic logic [22:0] cs_rom(input logic [5:0] a);
        case (a)
            6'h04, 6'h05: return CS_ADD;
            6'h00, 6'h01: return CS_BR;
            6'h1E, 6'h1F: return CS_STW;
            6'h3D, 6'h3C: return CS_TRAP;
            default:      return 23'h0;
        endcase
    endfunction

    function automatic logic [15:0] rf_val(input logic [2:0] r);
        return 16'hA000 + 16'(r) * 16'h0111;
    endfunction

    always_comb cs_bits = cs_rom(cs_addr);
    assign rf_sr1_data = rf_val(rf_sr1_addr);
    assign rf_sr2_data = rf_val(rf_sr2_addr);

    always #5 clk = ~clk;

    de_agex_latch dut (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_ir(de_ir), .de_npc(de_npc),
        .cs_addr(cs_addr), .cs_bits(cs_bits),
        .rf_sr1_addr(rf_sr1_addr), .rf_sr2_addr(rf_sr2_addr),
        .rf_sr1_data(rf_sr1_data), .rf_sr2_data(rf_sr2_data),
        .agex_drid_in(agex_drid_in), .mem_drid_in(mem_drid_in), .sr_drid_in(sr_drid_in),
        .agex_v_ld_reg(agex_v_ld_reg), .mem_v_ld_reg(mem_v_ld_reg), .sr_v_ld_reg(sr_v_ld_reg),
        .agex_v_ld_cc(agex_v_ld_cc), .mem_v_ld_cc(mem_v_ld_cc), .sr_v_ld_cc(sr_v_ld_cc),
        .ld_agex(ld_agex), .dep_stall(dep_stall), .v_de_br_stall(v_de_br_stall), .ld_de(ld_de),
        .agex_valid(agex_valid), .agex_npc(agex_npc), .agex_ir(agex_ir),
        .agex_sr1(agex_sr1), .agex_sr2(agex_sr2), .agex_cs(agex_cs), .agex_drid(agex_drid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        agex_v_ld_reg = 0; mem_v_ld_reg = 0; sr_v_ld_reg = 0;
        agex_v_ld_cc  = 0; mem_v_ld_cc  = 0; sr_v_ld_cc  = 0;
        agex_drid_in  = 0; mem_drid_in  = 0; sr_drid_in  = 0;
    endtask

    task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] npc);
        de_valid = v; de_ir = ir; de_npc = npc;
        #1;
    endtask

    initial begin
        rst = 1; ld_agex = 1;
        clear_hazards();
        drive(1'b1, IR_ADD, 16'h3002);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(agex_valid), 32'h0);
        check("reset_ir",    32'(agex_ir),    32'h0);
        check("reset_cs",    32'(agex_cs),    32'h0);
        rst = 0;

        // ADD R1,R2,R3: cs_addr = {00010,0}
        check("add_cs_addr", 32'(cs_addr),     32'h04);
        check("add_sr1",     32'(rf_sr1_addr), 32'd2);
        check("add_sr2",     32'(rf_sr2_addr), 32'd3);
        check("add_stall",   32'(dep_stall),   32'd0);
        check("add_ld_de",   32'(ld_de),       32'd1);
        step();
        check("add_valid",   32'(agex_valid), 32'd1);
        check("add_drid",    32'(agex_drid),  32'd1);
        check("add_op1",     32'(agex_sr1),   32'(rf_val(3'd2)));
        check("add_op2",     32'(agex_sr2),   32'(rf_val(3'd3)));
        check("add_cs",      32'(agex_cs),    32'(CS_ADD >> 3));
        check("add_npc",     32'(agex_npc),   32'h3002);

        // MEM writes R3 -> stall on SR2, bubble inserted
        mem_v_ld_reg = 1; mem_drid_in = 3'd3; #1;
        check("memhit_stall", 32'(dep_stall), 32'd1);
        check("memhit_ld_de", 32'(ld_de),     32'd0);
        step();
        check("memhit_bubble", 32'(agex_valid), 32'd0);
        check("memhit_ir",     32'(agex_ir),    32'(IR_ADD));
        clear_hazards(); #1;
        step();
        check("add_retry_valid", 32'(agex_valid), 32'd1);

        // AGEX writes R2 -> stall on SR1; same ID without a write pending does not
        agex_drid_in = 3'd2; agex_v_ld_reg = 1; #1;
        check("agexhit_stall", 32'(dep_stall), 32'd1);
        agex_v_ld_reg = 0; #1;
        check("agex_nold_stall", 32'(dep_stall), 32'd0);
        clear_hazards();

        // BRz: CC dependency from each stage
        drive(1'b1, IR_BRZ, 16'h3010);
        agex_v_ld_cc = 1; #1;
        check("br_agexcc_stall", 32'(dep_stall),     32'd1);
        check("br_brstall",      32'(v_de_br_stall), 32'd1);
        agex_v_ld_cc = 0; sr_v_ld_cc = 1; #1;
        check("br_srcc_stall",   32'(dep_stall),     32'd1);
        sr_v_ld_cc = 0; #1;
        check("br_nocc_stall",   32'(dep_stall),     32'd0);
        check("br_nocc_brstall", 32'(v_de_br_stall), 32'd1);

        // STW R4,R5,#0: SR2 from [11:9]
        drive(1'b1, IR_STW, 16'h3020);
        check("stw_sr2",   32'(rf_sr2_addr), 32'd4);
        check("stw_sr1",   32'(rf_sr1_addr), 32'd5);
        check("stw_nost",  32'(dep_stall),   32'd0);
        sr_v_ld_reg = 1; sr_drid_in = 3'd4; #1;
        check("stw_srhit", 32'(dep_stall),   32'd1);
        clear_hazards();

        // de_valid=0 masks hazards and produces a bubble
        drive(1'b1, IR_ADD, 16'h3030);
        step();
        check("pre_inv_valid", 32'(agex_valid), 32'd1);
        drive(1'b0, IR_BRZ, 16'h3032);
        agex_v_ld_cc = 1; #1;
        check("inv_stall",   32'(dep_stall),     32'd0);
        check("inv_brstall", 32'(v_de_br_stall), 32'd0);
        step();
        check("inv_valid",   32'(agex_valid), 32'd0);
        clear_hazards();

        // TRAP: DRMUX forces R7
        drive(1'b1, IR_TRAP, 16'h3040);
        check("trap_cs_addr", 32'(cs_addr), 32'h3D);
        step();
        check("trap_drid",  32'(agex_drid),  32'd7);
        check("trap_valid", 32'(agex_valid), 32'd1);

        // Hold: ld_agex=0 for 3 cycles with new inputs and a pending stall
        ld_agex = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, IR_STW, 16'h3050 + 16'(i));
            sr_v_ld_reg = 1; sr_drid_in = 3'd4; #1;
            check("hold_ld_de", 32'(ld_de), 32'd0);
            step();
        end
        check("hold_valid", 32'(agex_valid), 32'd1);
        check("hold_ir",    32'(agex_ir),    32'(IR_TRAP));
        check("hold_npc",   32'(agex_npc),   32'h3040);
        check("hold_drid",  32'(agex_drid),  32'd7);
        check("hold_cs",    32'(agex_cs),    32'(CS_TRAP >> 3));
        ld_agex = 1; #1;
        step();
        check("release_bubble", 32'(agex_valid), 32'd0);
        check("release_ir",     32'(agex_ir),    32'(IR_STW));
        check("release_op2",    32'(agex_sr2),   32'(rf_val(3'd4)));
        clear_hazards();

        // Asynchronous reset mid-cycle
        drive(1'b1, IR_ADD, 16'h3060);
        step();
        check("prerst_valid", 32'(agex_valid), 32'd1);
        #2 rst = 1;
        #1;
        check("arst_valid", 32'(agex_valid), 32'd0);
        check("arst_ir",    32'(agex_ir),    32'd0);
        check("arst_npc",   32'(agex_npc),   32'd0);
        check("arst_ops",   32'({agex_sr1, agex_sr2}), 32'd0);
        check("arst_drid",  32'(agex_drid),  32'd0);
        #1 rst = 0;
        step();
        check("post_rst_valid", 32'(agex_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
